// File: rtl/spike_delay_scheduler_pkg.sv
// Shared definitions for the spike delay scheduler and the current calculator.
// Holds FSM state encodings, a constant-safe clog2 helper and default sizing.
package spike_delay_scheduler_pkg;

  localparam int M_DEFAULT     = 24;
  localparam int D_MAX_DEFAULT = 3;
  localparam int DW_DEFAULT    = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_EMIT   = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions; returns at least 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/spike_history_lane.sv
// One synapse lane: (D_MAX+1)-deep spike history plus a saturating delay select.
// hist[0] holds the newest accepted timestep, hist[k] the one k steps older.
module spike_history_lane
  import spike_delay_scheduler_pkg::*;
#(
  parameter int D_MAX = D_MAX_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          shift,
  input  logic          spike,
  input  logic [DW-1:0] delay,
  output logic          delayed
);

  logic [D_MAX:0] hist;

  // Shift the new spike in on every accepted timestep; clear flushes the lane.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the history is a handful of flops, not a RAM, so it is safe and required to reset it.
    if (!reset_n) begin
      hist <= '0;
    end else if (clear) begin
      hist <= '0;
    end else if (shift) begin
      hist <= {hist[D_MAX-1:0], spike};
    end
  end

  // Pick the history tap; delay codes beyond D_MAX fall through to the oldest tap.
  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned (no latch).
    delayed = hist[D_MAX];
    for (int k = 0; k < D_MAX; k++) begin
      if (int'(delay) == k) delayed = hist[k];
    end
  end

endmodule

// File: rtl/spike_delay_scheduler.sv
// Spike delay scheduler: per-timestep spike history, per-synapse axonal delay,
// delayed spike vector plus one-cycle calc_enable strobe for the current calculator.
// Optional feature macro: SPIKE_COUNT_EN adds a registered popcount output.
module spike_delay_scheduler
  import spike_delay_scheduler_pkg::*;
#(
  parameter int M     = M_DEFAULT,
  parameter int D_MAX = D_MAX_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            step,
  input  logic [M-1:0]    in_spikes,
  input  logic [M*DW-1:0] delays,
  input  logic            clear,
  output logic [M-1:0]    input_spikes,
  output logic            calc_enable,
  output logic            busy,
  output logic            step_dropped
`ifdef SPIKE_COUNT_EN
  ,
  output logic [clog2(M+1)-1:0] spike_count
`endif
);

  state_t       state;
  logic         shift;
  logic [M-1:0] lane_out;

  // History only advances for a step taken in IDLE; clear wins over everything.
  assign shift = (state == S_IDLE) && step && !clear;
  assign busy  = (state != S_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_lane
      spike_history_lane #(
        .D_MAX (D_MAX),
        .DW    (DW)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .shift   (shift),
        .spike   (in_spikes[gi]),
        .delay   (delays[gi*DW +: DW]),
        .delayed (lane_out[gi])
      );
    end
  endgenerate

`ifdef SPIKE_COUNT_EN
  localparam int CW = clog2(M + 1);
  logic [CW-1:0] lane_ones;

  // Count ones in the vector about to be latched into input_spikes.
  always_comb begin
    lane_ones = '0;
    for (int i = 0; i < M; i++) begin
      lane_ones = lane_ones + CW'(lane_out[i]);
    end
  end
`endif

  // Timestep FSM: IDLE -> SELECT (latch delayed spikes) -> EMIT (drop strobe) -> IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      input_spikes <= '0;
      calc_enable  <= 1'b0;
      step_dropped <= 1'b0;
`ifdef SPIKE_COUNT_EN
      spike_count  <= '0;
`endif
    end else if (clear) begin
      state        <= S_IDLE;
      input_spikes <= '0;
      calc_enable  <= 1'b0;
      step_dropped <= 1'b0;
`ifdef SPIKE_COUNT_EN
      spike_count  <= '0;
`endif
    end else begin
      step_dropped <= 1'b0;
      case (state)
        S_IDLE: begin
          if (step) state <= S_SELECT;
        end
        S_SELECT: begin
          input_spikes <= lane_out;
          calc_enable  <= 1'b1;
          step_dropped <= step;
          state        <= S_EMIT;
`ifdef SPIKE_COUNT_EN
          spike_count  <= lane_ones;
`endif
        end
        S_EMIT: begin
          calc_enable  <= 1'b0;
          step_dropped <= step;
          state        <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_delay_scheduler.sv
// Self-checking bench for spike_delay_scheduler: a default instance (D_MAX=3)
// and a D_MAX=2 instance fed identical stimulus, checked against a queue-based
// history model, a hand-computed vector table and targeted corner sequences.
module tb_spike_delay_scheduler;

  typedef logic [23:0] vec_t;
  typedef logic [47:0] dly_t;

  typedef struct {
    vec_t in_v;
    dly_t dl;
    vec_t exp1;
    vec_t exp2;
  } row_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic step = 1'b0;
  logic clear = 1'b0;
  vec_t in_spikes = '0;
  dly_t delays = '0;

  vec_t out1, out2;
  logic ce1, ce2, busy1, busy2, sd1, sd2;
`ifdef SPIKE_COUNT_EN
  logic [4:0] cnt1, cnt2;
`endif

  int passed = 0;
  int total  = 0;

  vec_t hist_q[$];

  always #5 clk = ~clk;

  spike_delay_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .step         (step),
    .in_spikes    (in_spikes),
    .delays       (delays),
    .clear        (clear),
    .input_spikes (out1),
    .calc_enable  (ce1),
    .busy         (busy1),
    .step_dropped (sd1)
`ifdef SPIKE_COUNT_EN
    ,
    .spike_count  (cnt1)
`endif
  );

  spike_delay_scheduler #(.M(24), .D_MAX(2), .DW(2)) dut2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .step         (step),
    .in_spikes    (in_spikes),
    .delays       (delays),
    .clear        (clear),
    .input_spikes (out2),
    .calc_enable  (ce2),
    .busy         (busy2),
    .step_dropped (sd2)
`ifdef SPIKE_COUNT_EN
    ,
    .spike_count  (cnt2)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: newest accepted timestep at index 0; lane uses timestep min(d, dmax) back.
  function automatic vec_t model_out(input int dmax, input dly_t dl);
    vec_t r;
    r = '0;
    for (int i = 0; i < 24; i++) begin
      int d;
      d = int'(dl[i*2 +: 2]);
      if (d > dmax) d = dmax;
      if (d < hist_q.size()) r[i] = hist_q[d][i];
    end
    return r;
  endfunction

  task automatic accept(input vec_t v);
    hist_q.push_front(v);
    if (hist_q.size() > 4) void'(hist_q.pop_back());
  endtask

  // One full timestep with checks at every cycle of the handshake.
  task automatic run_step(input string tag, input vec_t v, input dly_t dl,
                          input vec_t e1, input vec_t e2);
    step = 1'b1;
    in_spikes = v;
    delays = dl;
    tick();
    step = 1'b0;
    check({tag, " busy@N"}, {62'd0, busy1, busy2}, 64'd3);
    check({tag, " ce@N"}, {62'd0, ce1, ce2}, 64'd0);
    tick();
    check({tag, " ce@N+1"}, {62'd0, ce1, ce2}, 64'd3);
    check({tag, " busy@N+1"}, {62'd0, busy1, busy2}, 64'd3);
    check({tag, " spikes"}, {40'd0, out1}, {40'd0, e1});
    check({tag, " spikes_d2"}, {40'd0, out2}, {40'd0, e2});
`ifdef SPIKE_COUNT_EN
    check({tag, " count"}, {59'd0, cnt1}, 64'($countones(e1)));
`endif
    tick();
    check({tag, " ce@N+2"}, {62'd0, ce1, ce2}, 64'd0);
    check({tag, " busy@N+2"}, {62'd0, busy1, busy2}, 64'd0);
    check({tag, " hold"}, {40'd0, out1}, {40'd0, e1});
  endtask

  task automatic model_step(input string tag, input vec_t v, input dly_t dl);
    vec_t e1, e2;
    accept(v);
    e1 = model_out(3, dl);
    e2 = model_out(2, dl);
    run_step(tag, v, dl, e1, e2);
  endtask

  row_t tbl[4];

  initial begin
    // Lane 0 delay code 3, lane 1 delay code 2, all other lanes delay 0.
    tbl[0] = '{24'h000001, 48'h00000000000B, 24'h000000, 24'h000000};
    tbl[1] = '{24'h000002, 48'h00000000000B, 24'h000000, 24'h000000};
    tbl[2] = '{24'h000000, 48'h00000000000B, 24'h000000, 24'h000001};
    tbl[3] = '{24'hFFFFFC, 48'h00000000000B, 24'hFFFFFF, 24'hFFFFFE};

    // Reset state.
    #2;
    check("reset spikes", {40'd0, out1}, 64'd0);
    check("reset ce/busy/sd", {61'd0, ce1, busy1, sd1}, 64'd0);
`ifdef SPIKE_COUNT_EN
    check("reset count", {59'd0, cnt1}, 64'd0);
`endif
    tick();
    reset_n = 1'b1;
    tick();

    // All delays zero: current timestep passes straight through.
    model_step("pass", 24'h00A5F0, '0);

    // Async reset in the middle of EMIT.
    step = 1'b1; in_spikes = 24'hFFFFFF; delays = '0;
    tick();
    step = 1'b0;
    tick();
    check("pre-reset ce", {63'd0, ce1}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("async spikes", {40'd0, out1}, 64'd0);
    check("async ce/busy/sd", {61'd0, ce1, busy1, sd1}, 64'd0);
    tick();
    reset_n = 1'b1;
    hist_q.delete();
    tick();

    // Hand-computed delay / saturation table.
    for (int r = 0; r < 4; r++) begin
      accept(tbl[r].in_v);
      run_step($sformatf("tbl%0d", r), tbl[r].in_v, tbl[r].dl, tbl[r].exp1, tbl[r].exp2);
    end

    // Step while busy: dropped, history untouched, single strobe.
    step = 1'b1; in_spikes = 24'h123456; delays = '0;
    accept(24'h123456);
    tick();
    in_spikes = 24'hABCDEF;
    tick();
    check("drop sd", {62'd0, sd1, sd2}, 64'd3);
    check("drop ce", {63'd0, ce1}, 64'd1);
    check("drop spikes", {40'd0, out1}, 64'h123456);
    step = 1'b0;
    tick();
    check("drop sd clr", {63'd0, sd1}, 64'd0);
    check("drop ce clr", {63'd0, ce1}, 64'd0);
    tick();
    check("drop no 2nd ce", {63'd0, ce1}, 64'd0);
    model_step("after drop", 24'h000000, 48'h555555555555);

    // Fill history with ones, then clear together with a step.
    for (int k = 0; k < 4; k++) model_step("ones", 24'hFFFFFF, '0);
`ifdef SPIKE_COUNT_EN
    check("count 24", {59'd0, cnt1}, 64'd24);
`endif
    clear = 1'b1; step = 1'b1;
    tick();
    clear = 1'b0; step = 1'b0;
    hist_q.delete();
    check("clear spikes", {40'd0, out1}, 64'd0);
    check("clear ce/busy/sd", {61'd0, ce1, busy1, sd1}, 64'd0);
`ifdef SPIKE_COUNT_EN
    check("clear count", {59'd0, cnt1}, 64'd0);
`endif
    tick();
    check("clear no ce", {62'd0, ce1, busy1}, 64'd0);
    model_step("post clear", 24'h000000, 48'hFFFFFFFFFFFF);

    // Randomized timesteps against the history model.
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      dly_t dl;
      if ($urandom_range(7) == 0) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
        hist_q.delete();
      end
      v = vec_t'($urandom);
      dl = {16'($urandom), 32'($urandom)};
      model_step($sformatf("rnd%0d", n), v, dl);
      repeat ($urandom_range(2)) tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
